// File: rtl/spi_dev_pkg.sv
// Shared definitions for the SPI device response path: FSM state encoding
// and the default byte driven when no source owns the read path.
package spi_dev_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] IDLE_BYTE_DEF = 8'hff;

endpackage

// File: rtl/spi_dev_cmd_match.sv
// Command byte decoder: compares the wrapper write byte against every
// source's command byte and returns a one-hot grant (lowest index wins)
// plus a hit flag.
module spi_dev_cmd_match #(
  parameter int                     N_SRC     = 4,
  parameter logic [8*N_SRC-1:0]     CMD_BYTES = 32'h13121110
) (
  input  logic [7:0]       wdata,
  output logic [N_SRC-1:0] grant,
  output logic             hit
);

  // Priority scan: once a match is found, higher indices are ignored.
  always_comb begin
    grant = '0;
    hit   = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!hit && (wdata == CMD_BYTES[8*i +: 8])) begin
        grant[i] = 1'b1;
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_dev_rsp_arb.sv
// Read-data arbiter for the SPI device protocol wrapper. The command byte of
// each transaction selects one response source, which owns pw_rdata until the
// transaction ends. One byte is prefetched from the owner into a holding
// register so pw_rdata is stable whenever the wrapper pulls a byte.
//
// Handshakes:
//   src_valid/src_ack : a source holds its byte on src_data while src_valid is
//                       high; a one-cycle src_ack means that byte was taken.
//   pw_rstb           : the wrapper consumed pw_rdata in this cycle; there is
//                       no back-pressure, so an empty holding register is an
//                       underrun.
//
// Optional build macro SPI_DEV_RSP_UNDERRUN_CNT_EN enables the saturating
// underrun counter; otherwise underrun_cnt is tied to zero.
module spi_dev_rsp_arb
  import spi_dev_pkg::*;
#(
  parameter int                 N_SRC     = 4,
  parameter logic [8*N_SRC-1:0] CMD_BYTES = 32'h13121110,
  parameter logic [7:0]         IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         pw_wdata,
  input  logic               pw_wcmd,
  input  logic               pw_wstb,
  input  logic               pw_end,
  output logic [7:0]         pw_rdata,
  input  logic               pw_rstb,
  output logic [N_SRC-1:0]   src_start,
  output logic [N_SRC-1:0]   src_sel,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_valid,
  output logic [N_SRC-1:0]   src_ack,
  output logic               err_underrun,
  output logic [7:0]         underrun_cnt,
  output logic [1:0]         dbg_state
);

  state_t             state, state_nxt;
  logic [N_SRC-1:0]   sel_q, sel_nxt;
  logic               hold_valid;
  logic [7:0]         rdata_q;
  logic               err_q;
  logic [N_SRC-1:0]   match_grant;
  logic               match_hit;
  logic [7:0]         owner_data;
  logic               new_cmd, restart, owner_valid;
  logic               prefetch, consume, underrun;

  spi_dev_cmd_match #(
    .N_SRC     (N_SRC),
    .CMD_BYTES (CMD_BYTES)
  ) u_cmd_match (
    .wdata (pw_wdata),
    .grant (match_grant),
    .hit   (match_hit)
  );

  // A command byte always restarts arbitration, as if the transaction ended.
  assign new_cmd     = pw_wstb & pw_wcmd;
  assign restart     = new_cmd | pw_end;
  assign owner_valid = |(src_valid & sel_q);

  // Consume takes precedence over prefetch; a restart overrides both.
  assign consume  = (state == ST_ACTIVE) && pw_rstb && !restart;
  assign underrun = consume && !hold_valid;
  assign prefetch = (state == ST_ACTIVE) && !hold_valid && owner_valid &&
                    !pw_rstb && !restart;

  // Select the owner's response byte from the one-hot owner vector.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel_q[i]) owner_data = owner_data | src_data[8*i +: 8];
    end
  end

  // FSM state and owner register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sel_q <= '0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
    end
  end

  // Next-state/owner decode and the per-source pulses.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    if (new_cmd) begin
      state_nxt = match_hit ? ST_GRANT : ST_IDLE;
      sel_nxt   = match_hit ? match_grant : '0;
    end else if (pw_end) begin
      state_nxt = ST_IDLE;
      sel_nxt   = '0;
    end else if (state == ST_GRANT) begin
      state_nxt = ST_ACTIVE;
    end
    src_start = (state == ST_GRANT) ? sel_q : '0;
    src_ack   = prefetch ? sel_q : '0;
  end

  // Holding register, registered read byte and underrun pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      rdata_q    <= IDLE_BYTE;
      err_q      <= 1'b0;
    end else begin
      err_q <= underrun;
      if (restart) begin
        hold_valid <= 1'b0;
        rdata_q    <= IDLE_BYTE;
      end else if (consume) begin
        if (hold_valid) hold_valid <= 1'b0;
        else            rdata_q    <= IDLE_BYTE;
      end else if (prefetch) begin
        hold_valid <= 1'b1;
        rdata_q    <= owner_data;
      end
    end
  end

`ifdef SPI_DEV_RSP_UNDERRUN_CNT_EN
  logic [7:0] cnt_q;

  // Saturating underrun counter, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            cnt_q <= 8'h00;
    else if (underrun && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
  end

  assign underrun_cnt = cnt_q;
`else
  assign underrun_cnt = 8'h00;
`endif

  assign src_sel      = sel_q;
  assign pw_rdata     = rdata_q;
  assign err_underrun = err_q;
  assign dbg_state    = state;

endmodule

// File: doc/spi_dev_rsp_arb.md
Name: spi_dev_rsp_arb

Overview:
- Shares the SPI device protocol wrapper's single read-data path between N response sources.
- Decodes the command byte of each SPI transaction and grants ownership to the matching source until transaction end.
- Prefetches one byte from the owner into a holding register so pw_rdata is always stable when the wrapper pulls a byte.
- Sits beside the short-command decoders on the wrapper's write interface; sources are status readers, FIFO drains and similar blocks.

Parameters:
- N_SRC, 4, number of response sources (1..8).
- CMD_BYTES, {8'h13,8'h12,8'h11,8'h10}, packed 8*N_SRC command bytes; source i owns bits [8i+7:8i].
- IDLE_BYTE, 8'hff, value driven on pw_rdata when there is no owner or on underrun.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pw_wdata  in  8  wrapper write byte
- pw_wcmd  in  1  qualifies pw_wdata as the command byte (first byte of transaction)
- pw_wstb  in  1  write byte strobe
- pw_end  in  1  transaction end (CS deassert) pulse
- pw_rdata  out  8  read byte presented to wrapper (registered)
- pw_rstb  in  1  wrapper consumed pw_rdata this cycle
- src_start  out  N_SRC  one-cycle pulse to new owner at grant
- src_sel  out  N_SRC  one-hot current owner, 0 when idle
- src_data  in  8*N_SRC  per-source response byte
- src_valid  in  N_SRC  per-source byte available
- src_ack  out  N_SRC  one-cycle pulse: byte of owner taken
- err_underrun  out  1  one-cycle pulse: pw_rstb with empty holding register while owned
- underrun_cnt  out  8  saturating underrun count (see Optional Feature)

Behaviour:
- Reset values: state IDLE, owner none, src_sel=0, src_start=0, src_ack=0, hold_valid=0, pw_rdata=IDLE_BYTE, err_underrun=0, underrun_cnt=0.
- States: IDLE, GRANT, ACTIVE.
- IDLE -> GRANT on pw_wstb&pw_wcmd with at least one CMD_BYTES match.
  - The lowest matching index wins.
  - src_sel is registered at that edge.
- With no match, stay IDLE; pw_rdata stays IDLE_BYTE for the whole transaction.
- GRANT lasts exactly one cycle: src_start[owner]=1, then -> ACTIVE.
- ACTIVE prefetch: when hold_valid=0 and src_valid[owner]=1, the same cycle does all of:
  - src_ack[owner]=1;
  - next edge loads pw_rdata<=src_data[owner] and sets hold_valid=1.
  - Prefetch latency is 1 cycle from valid to pw_rdata.
- ACTIVE consume on pw_rstb:
  - hold_valid=1: clear hold_valid; pw_rdata holds its value until the next prefetch load.
  - hold_valid=0: err_underrun=1 for one cycle; pw_rdata<=IDLE_BYTE.
- Consume and prefetch never occur in the same cycle. The prefetch condition uses registered hold_valid, so the next prefetch follows one cycle after the consume.
- pw_rstb in IDLE or GRANT: ignored; no underrun is flagged.
- pw_end in any state:
  - -> IDLE; src_sel=0; hold_valid=0; pw_rdata<=IDLE_BYTE.
  - A prefetched but unconsumed byte is discarded; sources must tolerate this.
- pw_end and pw_wstb&pw_wcmd in the same cycle: the end is applied, then the command is decoded, so a new grant proceeds.
- pw_wcmd while ACTIVE/GRANT without pw_end: treat as end followed by new command, same rule as above.
- src_ack is only ever asserted to the current owner; src_ack is 0 for all sources in IDLE/GRANT.
- Reset mid-transaction: immediate return to reset values; no src_ack or src_start glitch.

Optional Feature:
- Macro SPI_DEV_RSP_UNDERRUN_CNT_EN.
- Defined: underrun_cnt increments on each err_underrun, saturates at 8'hff, and is cleared only by rst.
- Undefined: underrun_cnt is tied to 8'h00 and no counter flops are inferred; err_underrun is unaffected.

Decomposition:
- Shared package (spi_dev_pkg): state encoding constants (ST_IDLE, ST_GRANT, ST_ACTIVE) and the default IDLE_BYTE constant 8'hff.
- Sub-module spi_dev_cmd_match: combinational N_SRC-way comparison of pw_wdata against CMD_BYTES, with a priority encoder outputting a one-hot grant vector and a hit flag.
- FSM, holding register and counter stay in the top block.

Test Plan:
- Cmd 8'h11, src1 valid with byte 8'hA5, then pw_rstb -> src_start=4'b0010 one cycle after cmd; src_ack[1] once; pw_rdata=8'hA5 before rstb.
- Cmd 8'h42 (no match), three pw_rstb -> src_sel=0, no src_ack, pw_rdata=8'hff throughout, err_underrun never asserted.
- Owner src2, src_valid low, pw_rstb -> err_underrun one pulse; pw_rdata=8'hff; underrun_cnt=1 with macro, 0 without.
- Owner src0 with byte 8'h5A prefetched, pw_end before rstb -> state IDLE, pw_rdata=8'hff; byte discarded; next cmd 8'h10 re-grants with src_start pulse.
- pw_end and cmd 8'h13 in same cycle -> src_sel=4'b1000 next edge, src_start[3] pulse; no residual hold from the prior owner.
- 300 underruns with macro defined -> underrun_cnt=8'hff (saturated); rst mid-ACTIVE -> all outputs return to reset values on the next edge.
